pc_sequencer: RTL and testbench

- Program-counter register and sequencer: the consumer side of the where-to-go path.
- Drives `pc` and `pc_4` into CmbWTG and takes back `pc_new` plus a redirect indication (jump or `branched`).
- Updates the PC each cycle, holds it under stall and latches a redirect that arrives during a stall.
- Halts on syscall and keeps run-statistics counters for the debug display.

---
 rtl/pc_sequencer_pkg.sv | 19 +
 rtl/pc_stat_counter.sv | 26 ++
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: state encoding,
// reset PC value and the word-alignment helper.
package pc_sequencer_pkg;

  localparam int PCS_ST_BIT = 2;

  typedef enum logic [PCS_ST_BIT-1:0] {
    PCS_ST_RUN  = 2'd0,
    PCS_ST_HOLD = 2'd1,
    PCS_ST_HALT = 2'd2
  } pcs_state_e;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_stat_counter.sv
// Free-running statistics counter with enable; wraps modulo 2^W.
module pc_stat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and sequencer: steps, holds under stall, latches
// redirects that arrive while stalled, halts on syscall and counts activity.
//
// Input timing: stall/halt/resume/redirect/pc_new are sampled on each rising
// edge and act on that edge; there is no handshake, every cycle is a transfer.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET,
  parameter int          CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  resume,
  input  logic                  redirect,
  input  logic [31:0]           pc_new,
  output logic [31:0]           pc,
  output logic [31:0]           pc_4,
  output logic                  halted,
  output logic                  pend_valid,
  output logic [CNT_W-1:0]      cycle_cnt,
  output logic [CNT_W-1:0]      redir_cnt,
  output logic [PCS_ST_BIT-1:0] dbg_state
);

  pcs_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] target;
  logic        redir_en;
  logic        cycle_en;

  assign target = align_pc(pc_new);
  assign pc_4   = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_d   = pend_q;
    redir_en = 1'b0;
    case (state_q)
      PCS_ST_RUN: begin
        if (halt) begin
          state_d = PCS_ST_HALT;
        end else if (redirect) begin
          redir_en = 1'b1;
          if (stall) begin
            pend_d  = target;
            state_d = PCS_ST_HOLD;
          end else begin
            pc_d = target;
          end
        end else if (!stall) begin
          pc_d = pc_4;
        end
      end
      PCS_ST_HOLD: begin
        // Already counted on entry; later redirects only replace the target.
        if (halt) begin
          state_d = PCS_ST_HALT;
          pend_d  = '0;
        end else if (stall) begin
          if (redirect) pend_d = target;
        end else begin
          pc_d    = redirect ? target : pend_q;
          pend_d  = '0;
          state_d = PCS_ST_RUN;
        end
      end
      PCS_ST_HALT: begin
        if (resume) state_d = PCS_ST_RUN;
      end
      default: begin
        state_d = PCS_ST_RUN;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PCS_ST_RUN;
      pc_q    <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
    end
  end

  assign cycle_en = (state_q != PCS_ST_HALT);

  pc_stat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (cycle_en),
    .cnt_o (cycle_cnt)
  );

  pc_stat_counter #(.W(CNT_W)) u_redir_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (redir_en),
    .cnt_o (redir_cnt)
  );

  assign pc         = pc_q;
  assign halted     = (state_q == PCS_ST_HALT);
  assign pend_valid = (state_q == PCS_ST_HOLD);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts the outputs
// after each edge and a monitor compares them one time unit after the edge.
module tb_pc_sequencer;

  localparam int VW = 98;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        resume = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] pc_new = '0;
  logic [31:0] pc, pc_4;
  logic        halted, pend_valid;
  logic [31:0] cycle_cnt, redir_cnt;
  logic [1:0]  dbg_state;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt       (halt),
    .resume     (resume),
    .redirect   (redirect),
    .pc_new     (pc_new),
    .pc         (pc),
    .pc_4       (pc_4),
    .halted     (halted),
    .pend_valid (pend_valid),
    .cycle_cnt  (cycle_cnt),
    .redir_cnt  (redir_cnt),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model
  logic [31:0] m_pc, m_pend, m_cyc, m_red;
  logic        m_halted, m_pend_on;

  logic [VW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [VW-1:0] pack(input logic [31:0] p, input logic h,
                                         input logic pv, input logic [31:0] c,
                                         input logic [31:0] r);
    return {p, h, pv, c, r};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return pack(pc, halted, pend_valid, cycle_cnt, redir_cnt);
  endfunction

  task automatic check_vec(input string name, input logic [VW-1:0] act,
                           input logic [VW-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s t=%0t: got pc=%h halted=%b pend=%b cyc=%0d red=%0d, want pc=%h halted=%b pend=%b cyc=%0d red=%0d",
               name, $time, act[97:66], act[65], act[64], act[63:32], act[31:0],
               exp[97:66], exp[65], exp[64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, act, exp);
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_pend = 32'h0; m_cyc = 32'h0; m_red = 32'h0;
    m_halted = 1'b0; m_pend_on = 1'b0;
  endtask

  // One clock edge of architectural behaviour, straight from the rules.
  task automatic model_step(input logic s, input logic h, input logic r,
                            input logic rd, input logic [31:0] tgt);
    logic [31:0] a;
    a = tgt & 32'hFFFF_FFFC;
    if (m_halted) begin
      if (r) m_halted = 1'b0;
    end else begin
      m_cyc = m_cyc + 1;
      if (h) begin
        m_halted = 1'b1; m_pend_on = 1'b0; m_pend = 0;
      end else if (m_pend_on) begin
        if (s) begin
          if (rd) m_pend = a;
        end else begin
          m_pc = rd ? a : m_pend;
          m_pend_on = 1'b0;
        end
      end else if (rd) begin
        m_red = m_red + 1;
        if (s) begin m_pend = a; m_pend_on = 1'b1; end
        else m_pc = a;
      end else if (!s) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // driver tasks
  task automatic apply(input logic s, input logic h, input logic r,
                       input logic rd, input logic [31:0] tgt);
    stall = s; halt = h; resume = r; redirect = rd; pc_new = tgt;
    model_step(s, h, r, rd, tgt);
    exp_q.push_back(pack(m_pc, m_halted, m_pend_on, m_cyc, m_red));
  endtask

  task automatic step(input logic s, input logic h, input logic r,
                      input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    apply(s, h, r, rd, tgt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check_vec("cycle", dut_vec(), exp_q.pop_front());
    end
  end

  initial begin
    model_reset();
    #12;
    check_vec("reset", dut_vec(), pack(32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(3);

    // redirect with unaligned target at pc 0x10
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_1002);

    // redirect during stall, then overwritten while still stalled
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1);

    // halt with same-cycle redirect at pc 0x40; inputs ignored while halted
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0999);
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
           1'($urandom_range(0, 1)), $urandom);
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    idle(2);

    // wrap-around
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 40) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
           $urandom);

    // asynchronous reset while holding a pending redirect
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_2000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_vec("reset_mid_hold", dut_vec(), pack(32'h0, 1'b0, 1'b0, 32'h0, 32'h0));
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    idle(1);

    @(posedge clk);
    #2;
    check_int("drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
